// File: rtl/fm_radio_pkg.sv
// Shared FM-radio constants: quantization scale, dequantize helper and the
// low-pass coefficient table used by the decimating FIR.
package fm_radio_pkg;

  localparam int QUANT_BITS = 10;
  localparam int COEF_COUNT = 32;

  typedef logic signed [31:0] coef_t;
  typedef coef_t coef_array_t [0:COEF_COUNT-1];

  localparam coef_array_t COEFS = '{
    32'sd1,   -32'sd3,  -32'sd6,  -32'sd12, -32'sd19, -32'sd27, -32'sd33, -32'sd30,
    -32'sd13, 32'sd21,  32'sd78,  32'sd155, 32'sd249, 32'sd349, 32'sd446, 32'sd526,
    32'sd526, 32'sd446, 32'sd349, 32'sd249, 32'sd155, 32'sd78,  32'sd21,  -32'sd13,
    -32'sd30, -32'sd33, -32'sd27, -32'sd19, -32'sd12, -32'sd6,  -32'sd3,  32'sd1
  };

  // Signed divide by 2^QUANT_BITS rounding toward zero: negative values get a
  // bias of 2^QUANT_BITS-1 so the arithmetic shift does not round toward -inf.
  function automatic logic signed [63:0] DEQUANTIZE(input logic signed [63:0] value);
    logic signed [63:0] bias;
    if (value < 64'sd0) begin
      bias = (64'sd1 <<< QUANT_BITS) - 64'sd1;
    end else begin
      bias = 64'sd0;
    end
    return (value + bias) >>> QUANT_BITS;
  endfunction

endpackage

// File: rtl/fir_decim_quant_mac.sv
// Multiply, dequantize and accumulate stage of the decimating FIR; the
// accumulator wraps and is cleared synchronously when a result is consumed.
module quant_mac
  import fm_radio_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] coef,
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic signed [DATA_WIDTH-1:0] acc
);

  logic signed [DATA_WIDTH-1:0] prod_s;
  logic signed [DATA_WIDTH-1:0] deq_s;
  logic signed [DATA_WIDTH-1:0] acc_r;

  // Product keeps only the low DATA_WIDTH bits before dequantizing.
  always_comb begin
    prod_s = coef * sample;
    deq_s  = DATA_WIDTH'(DEQUANTIZE(64'(prod_s)));
  end

  // Accumulator register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_r <= '0;
    end else if (clear) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + deq_s;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/fir_decim.sv
// Decimating FIR: loads DECIM samples from an upstream FIFO, runs a TAPS-cycle
// serial MAC over the sample history, then writes one result downstream.
module fir_decim
  import fm_radio_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 32,
  parameter int DECIM      = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int LOAD_W = $clog2(DECIM + 1);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]                   state_r;
  logic [LOAD_W-1:0]            load_cnt_r;
  logic [TAP_W-1:0]             tap_cnt_r;
  logic signed [DATA_WIDTH-1:0] shift_r [TAPS];
  logic signed [DATA_WIDTH-1:0] coef_s;
  logic signed [DATA_WIDTH-1:0] sample_s;
  logic signed [DATA_WIDTH-1:0] acc_s;
  logic                         rd_en_s;
  logic                         wr_en_s;

  // FIFO handshakes; reset_n gating keeps both strobes low while in reset.
  always_comb begin
    rd_en_s = 1'b0;
    wr_en_s = 1'b0;
    case (state_r)
      S_LOAD:  rd_en_s = reset_n & ~in_empty;
      S_WRITE: wr_en_s = reset_n & ~out_full;
      default: begin
        rd_en_s = 1'b0;
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Control FSM with load and tap counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_LOAD;
      load_cnt_r <= '0;
      tap_cnt_r  <= '0;
    end else begin
      case (state_r)
        S_LOAD: begin
          if (rd_en_s) begin
            load_cnt_r <= load_cnt_r + LOAD_W'(1);
            if (load_cnt_r == LOAD_W'(DECIM - 1)) begin
              state_r <= S_MAC;
            end
          end
        end
        S_MAC: begin
          tap_cnt_r <= tap_cnt_r + TAP_W'(1);
          if (tap_cnt_r == TAP_W'(TAPS - 1)) begin
            tap_cnt_r <= '0;
            state_r   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wr_en_s) begin
            load_cnt_r <= '0;
            state_r    <= S_LOAD;
          end
        end
        default: begin
          state_r    <= S_LOAD;
          load_cnt_r <= '0;
          tap_cnt_r  <= '0;
        end
      endcase
    end
  end

  // Sample history; it is never cleared between output groups.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TAPS; k++) begin
        shift_r[k] <= '0;
      end
    end else if (rd_en_s) begin
      for (int k = TAPS - 1; k > 0; k--) begin
        shift_r[k] <= shift_r[k-1];
      end
      shift_r[0] <= in_dout;
    end
  end

  // Tap operand selection for the serial MAC.
  always_comb begin
    coef_s   = DATA_WIDTH'(COEFS[tap_cnt_r]);
    sample_s = shift_r[tap_cnt_r];
  end

  quant_mac #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_quant_mac (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (wr_en_s),
    .en     (state_r == S_MAC),
    .coef   (coef_s),
    .sample (sample_s),
    .acc    (acc_s)
  );

  assign in_rd_en  = rd_en_s;
  assign out_wr_en = wr_en_s;
  assign out_din   = acc_s;

endmodule
